// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one external memory block port between the I-cache miss path and
//   the D-cache miss/write-back path. Only one block transaction is in flight
//   at a time. Simultaneous requests are resolved round-robin. A watchdog
//   raises a sticky error flag when a grant waits too long for memory.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   i_ren/i_addr    I-cache block read request (held until i_ready)
//   i_rdata/i_ready read block and 1-cycle completion pulse to the I-cache
//   d_ren/d_wen     D-cache block read / write request (write wins when both)
//   d_addr/d_wdata  D-cache block address and write-back data
//   d_rdata/d_ready read block and 1-cycle completion pulse to the D-cache
//   mem_ren/mem_wen memory strobes, held until mem_ready
//   mem_addr/wdata  memory block address and write data
//   mem_rdata/ready memory read data and 1-cycle completion
//   busy            high whenever the arbiter is not idle
//   timeout_err     sticky watchdog flag, cleared only by rst
module mem_port_arbiter #(
  parameter int ADDR_W   = 28,
  parameter int DATA_W   = 128,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ren,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              timeout_err
);

  // Counter is just wide enough to reach MAX_WAIT; it saturates at all-ones.
  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_I = 2'd1,
    S_GRANT_D = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              last_d_q, last_d_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              mem_ren_q, mem_ren_d;
  logic              mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic              i_ready_q, i_ready_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_ready_q, d_ready_d;
  logic              busy_q, busy_d;
  logic              timeout_err_q, timeout_err_d;
  logic              d_req;
  logic              pick_d;

  // Next-state and registered-output logic. In IDLE the D side wins when it
  // is the only requester, or on a tie when I was granted last; this makes
  // the first tie after reset go to D.
  always_comb begin
    state_d       = state_q;
    last_d_d      = last_d_q;
    wait_cnt_d    = wait_cnt_q;
    mem_ren_d     = mem_ren_q;
    mem_wen_d     = mem_wen_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;
    i_ready_d     = 1'b0;
    d_ready_d     = 1'b0;
    timeout_err_d = timeout_err_q;
    d_req         = d_ren | d_wen;
    pick_d        = d_req && (!i_ren || !last_d_q);

    case (state_q)
      S_IDLE: begin
        if (pick_d) begin
          state_d     = S_GRANT_D;
          last_d_d    = 1'b1;
          wait_cnt_d  = '0;
          mem_wen_d   = d_wen;
          mem_ren_d   = ~d_wen;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (i_ren) begin
          state_d    = S_GRANT_I;
          last_d_d   = 1'b0;
          wait_cnt_d = '0;
          mem_ren_d  = 1'b1;
          mem_wen_d  = 1'b0;
          mem_addr_d = i_addr;
        end
      end

      S_GRANT_I, S_GRANT_D: begin
        if (wait_cnt_q != CNT_SAT) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
        if ((MAX_WAIT != 0) && (wait_cnt_q == CNT_LIMIT)) begin
          timeout_err_d = 1'b1;
        end
        // Completion: only reads return data; a write leaves the block untouched.
        if (mem_ready) begin
          state_d   = S_DONE;
          mem_ren_d = 1'b0;
          mem_wen_d = 1'b0;
          if (state_q == S_GRANT_I) begin
            i_ready_d = 1'b1;
            if (mem_ren_q) i_rdata_d = mem_rdata;
          end else begin
            d_ready_d = 1'b1;
            if (mem_ren_q) d_rdata_d = mem_rdata;
          end
        end
      end

      // Dead cycle giving the requester time to drop its request.
      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_d_q      <= 1'b0;
      wait_cnt_q    <= '0;
      mem_ren_q     <= 1'b0;
      mem_wen_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      i_rdata_q     <= '0;
      i_ready_q     <= 1'b0;
      d_rdata_q     <= '0;
      d_ready_q     <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_d_q      <= last_d_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_ren_q     <= mem_ren_d;
      mem_wen_q     <= mem_wen_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      i_rdata_q     <= i_rdata_d;
      i_ready_q     <= i_ready_d;
      d_rdata_q     <= d_rdata_d;
      d_ready_q     <= d_ready_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign i_rdata     = i_rdata_q;
  assign i_ready     = i_ready_q;
  assign d_rdata     = d_rdata_q;
  assign d_ready     = d_ready_q;
  assign mem_ren     = mem_ren_q;
  assign mem_wen     = mem_wen_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter. A scoreboard queue holds the
//   transactions expected in grant order; each memory grant and each ready
//   pulse is checked against the front of the queue.
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 28;
  localparam int DATA_W   = 128;
  localparam int MAX_WAIT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_ren;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;
  logic              d_ren;
  logic              d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              busy;
  logic              timeout_err;

  mem_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_ren      (i_ren),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_ready    (i_ready),
    .d_ren      (d_ren),
    .d_wen      (d_wen),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_ready    (d_ready),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              is_d;
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
  } txn_t;

  typedef struct {
    logic              i_rd;
    logic              d_rd;
    logic              d_wr;
    logic [ADDR_W-1:0] i_addr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] pattern;
    int                lat;
    logic              first_d;
  } vec_t;

  txn_t              exp_q[$];
  vec_t              vecs[8];
  int                checks = 0;
  int                failures = 0;
  int                ready_seen = 0;
  int                mem_cnt = 0;
  int                mem_lat = 0;
  logic              strobe_prev = 1'b0;
  logic              auto_mem = 1'b0;
  logic              mix_addr = 1'b0;
  logic [DATA_W-1:0] rd_pattern = '0;
  logic [DATA_W-1:0] last_d_rdata = '0;

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  function automatic txn_t mkTxn(input logic is_d, input logic is_wr,
                                 input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata,
                                 input logic [DATA_W-1:0] rdata);
    txn_t t;
    t.is_d  = is_d;
    t.is_wr = is_wr;
    t.addr  = addr;
    t.wdata = wdata;
    t.rdata = rdata;
    return t;
  endfunction

  // One clock: sample outputs after the edge, score grants and ready pulses,
  // let requesters drop on their ready, and play the memory responder.
  task automatic stepCycle();
    logic strobe;
    txn_t t;
    @(posedge clk);
    #1;
    strobe = mem_ren | mem_wen;
    if (strobe) checkOutput("ren_wen_exclusive", DATA_W'(mem_ren & mem_wen), '0);
    if (strobe && !strobe_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_grant actual=grant required=none addr=%0h", mem_addr);
      end else begin
        t = exp_q[0];
        checkOutput("grant_mem_ren", DATA_W'(mem_ren), DATA_W'(!t.is_wr));
        checkOutput("grant_mem_wen", DATA_W'(mem_wen), DATA_W'(t.is_wr));
        checkOutput("grant_mem_addr", DATA_W'(mem_addr), DATA_W'(t.addr));
        if (t.is_wr) checkOutput("grant_mem_wdata", mem_wdata, t.wdata);
        checkOutput("grant_busy", DATA_W'(busy), DATA_W'(1'b1));
      end
      mem_cnt = 0;
    end
    if (i_ready || d_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL spurious_ready actual=i%0b/d%0b required=none", i_ready, d_ready);
      end else begin
        t = exp_q.pop_front();
        ready_seen++;
        checkOutput("ready_side_i", DATA_W'(i_ready), DATA_W'(!t.is_d));
        checkOutput("ready_side_d", DATA_W'(d_ready), DATA_W'(t.is_d));
        if (t.is_d) begin
          if (!t.is_wr) last_d_rdata = t.rdata;
          checkOutput("d_rdata", d_rdata, last_d_rdata);
        end else begin
          checkOutput("i_rdata", i_rdata, t.rdata);
        end
      end
    end
    if (i_ready) i_ren = 1'b0;
    if (d_ready) begin
      d_ren = 1'b0;
      d_wen = 1'b0;
    end
    mem_ready = 1'b0;
    mem_rdata = {4{$urandom()}};
    if (strobe && auto_mem) begin
      if (mem_cnt == mem_lat) begin
        mem_ready = 1'b1;
        mem_rdata = mix_addr ? (rd_pattern ^ DATA_W'(mem_addr)) : rd_pattern;
      end
      mem_cnt++;
    end
    strobe_prev = strobe;
  endtask

  task automatic waitDone(input string name, input int budget);
    int  n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      stepCycle();
      n++;
      done = (exp_q.size() == 0) && !busy && !i_ren && !d_ren && !d_wen;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL %s actual=pending%0d required=pending0 after %0d cycles",
               name, exp_q.size(), budget);
      exp_q.delete();
      i_ren = 1'b0;
      d_ren = 1'b0;
      d_wen = 1'b0;
    end
  endtask

  // Drive one table vector and queue its transactions in predicted grant order.
  task automatic applyStimulus(input vec_t v);
    txn_t ti;
    txn_t td;
    i_addr     = v.i_addr;
    d_addr     = v.d_addr;
    d_wdata    = v.d_wdata;
    rd_pattern = v.pattern;
    mem_lat    = v.lat;
    mix_addr   = 1'b1;
    auto_mem   = 1'b1;
    ti = mkTxn(1'b0, 1'b0, v.i_addr, '0, v.pattern ^ DATA_W'(v.i_addr));
    td = mkTxn(1'b1, v.d_wr, v.d_addr, v.d_wdata, v.pattern ^ DATA_W'(v.d_addr));
    if (v.i_rd && (v.d_rd || v.d_wr)) begin
      if (v.first_d) begin
        exp_q.push_back(td);
        exp_q.push_back(ti);
      end else begin
        exp_q.push_back(ti);
        exp_q.push_back(td);
      end
    end else if (v.i_rd) begin
      exp_q.push_back(ti);
    end else begin
      exp_q.push_back(td);
    end
    i_ren = v.i_rd;
    d_ren = v.d_rd;
    d_wen = v.d_wr;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    logic [DATA_W-1:0] pat;
    int                exp_n;

    // i_rd d_rd d_wr i_addr d_addr d_wdata pattern lat first_d
    vecs[0] = '{1'b1, 1'b1, 1'b0, 28'h0000020, 28'h0000030, '0,
                128'h1111_2222_3333_4444_5555_6666_7777_8888, 1, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 28'h0000040, 28'h0000050, '0,
                128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F, 0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 28'h0, 28'h0000002, 128'h1234,
                128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF, 2, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 28'h0000060, 28'h0000070,
                128'hCAFE_0000_0000_0000_0000_0000_0000_BABE,
                128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA, 1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 28'hFFFFFFF, 28'h0, '0,
                128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 3, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 28'h0, 28'hFFFFFFF, '0,
                128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, 0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 28'h0000080, 28'h0000090, '0,
                128'h8000_0000_0000_0000_0000_0000_0000_0001, 2, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 28'h0, 28'h0, '0,
                128'h7E7E_7E7E_7E7E_7E7E_7E7E_7E7E_7E7E_7E7E, 1, 1'b0};

    rst       = 1'b1;
    i_ren     = 1'b0;
    d_ren     = 1'b0;
    d_wen     = 1'b0;
    i_addr    = '0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;

    // Reset state
    stepCycle();
    stepCycle();
    checkOutput("rst_mem_strobes", DATA_W'({mem_ren, mem_wen}), '0);
    checkOutput("rst_mem_addr", DATA_W'(mem_addr), '0);
    checkOutput("rst_mem_wdata", mem_wdata, '0);
    checkOutput("rst_readies", DATA_W'({i_ready, d_ready}), '0);
    checkOutput("rst_rdata", i_rdata | d_rdata, '0);
    checkOutput("rst_busy_err", DATA_W'({busy, timeout_err}), '0);
    rst = 1'b0;
    stepCycle();

    // I-only read returning A5..A5 after a few memory cycles
    ready_seen = 0;
    auto_mem   = 1'b1;
    mix_addr   = 1'b0;
    mem_lat    = 3;
    rd_pattern = {16{8'hA5}};
    i_addr     = 28'h0000010;
    exp_q.push_back(mkTxn(1'b0, 1'b0, 28'h0000010, '0, {16{8'hA5}}));
    i_ren = 1'b1;
    stepCycle();
    checkOutput("t1_strobe_latency", DATA_W'(mem_ren), DATA_W'(1'b1));
    waitDone("t1_done", 20);
    checkOutput("t1_ready_count", DATA_W'(ready_seen), DATA_W'(1));
    checkOutput("t1_i_rdata_hold", i_rdata, {16{8'hA5}});

    // Table: ties after reset, write priority, address extremes, round-robin
    for (int k = 0; k < 8; k++) begin
      ready_seen = 0;
      exp_n = (vecs[k].i_rd ? 1 : 0) + ((vecs[k].d_rd || vecs[k].d_wr) ? 1 : 0);
      applyStimulus(vecs[k]);
      waitDone("vec_done", 40);
      checkOutput("vec_ready_count", DATA_W'(ready_seen), DATA_W'(exp_n));
    end
    checkOutput("no_timeout_yet", DATA_W'(timeout_err), '0);

    // mem_ready while idle is ignored; an I request dropped mid-grant completes
    auto_mem   = 1'b0;
    ready_seen = 0;
    mem_ready  = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("t6_idle_no_ready", DATA_W'({i_ready, d_ready}), '0);
    checkOutput("t6_idle_busy", DATA_W'(busy), '0);
    pat    = 128'h0BAD_F00D_0000_1111_2222_3333_4444_5555;
    i_addr = 28'h0000055;
    exp_q.push_back(mkTxn(1'b0, 1'b0, 28'h0000055, '0, pat));
    i_ren = 1'b1;
    stepCycle();
    checkOutput("t6_grant", DATA_W'(mem_ren), DATA_W'(1'b1));
    i_ren = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("t6_strobe_held", DATA_W'(mem_ren), DATA_W'(1'b1));
    mem_ready = 1'b1;
    mem_rdata = pat;
    stepCycle();
    waitDone("t6_done", 10);
    checkOutput("t6_ready_count", DATA_W'(ready_seen), DATA_W'(1));

    // Watchdog: memory withheld for 20 grant cycles
    ready_seen = 0;
    pat    = 128'h0000_0000_0000_0000_0000_0000_0000_C0DE;
    d_addr = 28'h0000077;
    exp_q.push_back(mkTxn(1'b1, 1'b0, 28'h0000077, '0, pat));
    d_ren = 1'b1;
    stepCycle();
    for (int c = 0; c < 4; c++) stepCycle();
    checkOutput("t4_err_early", DATA_W'(timeout_err), '0);
    for (int c = 0; c < 10; c++) stepCycle();
    checkOutput("t4_err_set", DATA_W'(timeout_err), DATA_W'(1'b1));
    for (int c = 0; c < 6; c++) stepCycle();
    checkOutput("t4_still_waiting", DATA_W'(mem_ren), DATA_W'(1'b1));
    mem_ready = 1'b1;
    mem_rdata = pat;
    stepCycle();
    waitDone("t4_done", 10);
    checkOutput("t4_ready_count", DATA_W'(ready_seen), DATA_W'(1));
    checkOutput("t4_err_sticky", DATA_W'(timeout_err), DATA_W'(1'b1));

    // Reset two cycles into a grant abandons the transaction
    d_addr = 28'h0000099;
    exp_q.push_back(mkTxn(1'b1, 1'b0, 28'h0000099, '0, '0));
    d_ren = 1'b1;
    stepCycle();
    stepCycle();
    rst = 1'b1;
    stepCycle();
    checkOutput("t5_rst_strobe", DATA_W'({mem_ren, mem_wen}), '0);
    checkOutput("t5_rst_busy", DATA_W'(busy), '0);
    checkOutput("t5_rst_ready", DATA_W'({i_ready, d_ready}), '0);
    checkOutput("t5_rst_err", DATA_W'(timeout_err), '0);
    checkOutput("t5_rst_d_rdata", d_rdata, '0);
    exp_q.delete();
    last_d_rdata = '0;
    d_ren = 1'b0;
    rst   = 1'b0;
    mem_ready = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("t5_late_ready_ignored", DATA_W'({i_ready, d_ready, busy}), '0);
    ready_seen = 0;
    vecs[0] = '{1'b0, 1'b1, 1'b0, 28'h0, 28'h00000AB, '0,
                128'h1357_9BDF_2468_ACE0_1357_9BDF_2468_ACE0, 1, 1'b0};
    applyStimulus(vecs[0]);
    waitDone("t5_fresh_done", 20);
    checkOutput("t5_fresh_ready_count", DATA_W'(ready_seen), DATA_W'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
